// File: rtl/cmd_seq_pkg.sv
// Shared types and constants for the Knight command sequencer,
// its benches and the tour image generator.
package cmd_seq_pkg;

    typedef enum logic [2:0] {
        S_IDLE,
        S_SEND,
        S_WAIT_SNT,
        S_WAIT_RESP,
        S_NEXT,
        S_DONE,
        S_ERR
    } state_t;

    typedef enum logic [1:0] {
        ERR_NONE  = 2'd0,
        ERR_TMO   = 2'd1,
        ERR_NAK   = 2'd2,
        ERR_ABORT = 2'd3
    } err_t;

    localparam logic [7:0]  ACK_BYTE = 8'hA5;
    localparam logic [7:0]  NAK_BYTE = 8'h5A;

    // Knight opcodes live in the top nibble of the command word
    localparam logic [15:0] CAL_GYRO = 16'h2000;
    localparam logic [15:0] MOVE     = 16'h4000;
    localparam logic [15:0] TOUR     = 16'h6000;

endpackage

// File: rtl/cmd_sequencer_mem.sv
// Command slot storage: synchronous write, asynchronous read, no reset.
module cmd_mem #(
    parameter int DEPTH = 16,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          i_we,
    input  logic [AW-1:0] i_waddr,
    input  logic [15:0]   i_wdata,
    input  logic [AW-1:0] i_raddr,
    output logic [15:0]   o_rdata
);

    logic [15:0] r_mem [DEPTH];

    always_ff @(posedge clk) begin
        if (i_we) r_mem[i_waddr] <= i_wdata;
    end

    assign o_rdata = r_mem[i_raddr];

endmodule

// File: rtl/cmd_sequencer.sv
// Plays a stored list of Knight commands into RemoteComm, one send/ack at a
// time, with per-command timeout, bounded retry, abort and error reporting.
import cmd_seq_pkg::*;

module cmd_sequencer #(
    parameter int         DEPTH     = 16,
    parameter int         TMO_W     = 24,
    parameter int         MAX_RETRY = 2,
    parameter logic [7:0] ACK       = 8'hA5,
    localparam int        AW        = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [AW-1:0]    wr_addr,
    input  logic [15:0]      wr_data,
    input  logic [AW:0]      num_cmds,
    input  logic [TMO_W-1:0] tmo_val,
    input  logic             start,
    input  logic             abort,
    output logic [15:0]      cmd,
    output logic             snd_cmd,
    input  logic             cmd_snt,
    input  logic             resp_rdy,
    input  logic [7:0]       resp,
    output logic             busy,
    output logic             done,
    output logic             error,
    output logic [1:0]       err_code,
    output logic [AW-1:0]    cur_idx
);

    state_t           r_state;
    err_t             r_err_code;
    logic [AW-1:0]    r_idx;
    logic [AW:0]      r_num;
    logic [TMO_W-1:0] r_tmo;
    logic [TMO_W-1:0] r_cnt;
    logic [7:0]       r_retry;
    logic [15:0]      r_cmd;
    logic             r_snd, r_busy, r_done, r_error;

    logic [AW-1:0]    w_rd_addr;
    logic [15:0]      w_rd_data;
    logic             w_ack, w_fail, w_last, w_active;
    err_t             w_fail_code;

    // Read address is the slot the next SEND will load, so cmd can be
    // registered on the same edge that enters SEND.
    always_comb begin
        w_rd_addr = r_idx;
        if (r_state == S_IDLE)      w_rd_addr = '0;
        else if (r_state == S_NEXT) w_rd_addr = r_idx + AW'(1);
    end

    always_comb begin
        w_ack       = resp_rdy && (resp == ACK);
        w_fail      = resp_rdy ? (resp != ACK) : (r_cnt == r_tmo - TMO_W'(1));
        w_fail_code = resp_rdy ? ERR_NAK : ERR_TMO;
        w_last      = ({1'b0, r_idx} == r_num - (AW+1)'(1));
        w_active    = (r_state == S_SEND) || (r_state == S_WAIT_SNT) ||
                      (r_state == S_WAIT_RESP) || (r_state == S_NEXT);
    end

    cmd_mem #(.DEPTH(DEPTH), .AW(AW)) u_mem (
        .clk     (clk),
        .i_we    (wr_en && !r_busy),
        .i_waddr (wr_addr),
        .i_wdata (wr_data),
        .i_raddr (w_rd_addr),
        .o_rdata (w_rd_data)
    );

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state    <= S_IDLE;
            r_err_code <= ERR_NONE;
            r_idx      <= '0;
            r_num      <= '0;
            r_tmo      <= '0;
            r_cnt      <= '0;
            r_retry    <= '0;
            r_cmd      <= '0;
            r_snd      <= 1'b0;
            r_busy     <= 1'b0;
            r_done     <= 1'b0;
            r_error    <= 1'b0;
        end else begin
            r_snd <= 1'b0;
            if (abort && w_active) begin
                r_state    <= S_ERR;
                r_err_code <= ERR_ABORT;
                r_error    <= 1'b1;
                r_busy     <= 1'b0;
            end else begin
                case (r_state)
                    S_IDLE: if (start) begin
                        r_error    <= 1'b0;
                        r_err_code <= ERR_NONE;
                        if (num_cmds == '0) begin
                            r_done  <= 1'b1;
                            r_state <= S_DONE;
                        end else begin
                            r_done  <= 1'b0;
                            r_num   <= num_cmds;
                            r_tmo   <= (tmo_val == '0) ? TMO_W'(1) : tmo_val;
                            r_idx   <= '0;
                            r_retry <= '0;
                            r_busy  <= 1'b1;
                            r_cmd   <= w_rd_data;
                            r_snd   <= 1'b1;
                            r_state <= S_SEND;
                        end
                    end
                    S_SEND: r_state <= S_WAIT_SNT;
                    S_WAIT_SNT: if (cmd_snt) begin
                        r_cnt   <= '0;
                        r_state <= S_WAIT_RESP;
                    end
                    S_WAIT_RESP: begin
                        if (w_ack) begin
                            r_state <= S_NEXT;
                        end else if (w_fail) begin
                            if (r_retry < 8'(MAX_RETRY)) begin
                                r_retry <= r_retry + 8'd1;
                                r_cmd   <= w_rd_data;
                                r_snd   <= 1'b1;
                                r_state <= S_SEND;
                            end else begin
                                r_err_code <= w_fail_code;
                                r_error    <= 1'b1;
                                r_busy     <= 1'b0;
                                r_state    <= S_ERR;
                            end
                        end else begin
                            r_cnt <= r_cnt + TMO_W'(1);
                        end
                    end
                    S_NEXT: begin
                        if (w_last) begin
                            r_done  <= 1'b1;
                            r_busy  <= 1'b0;
                            r_state <= S_DONE;
                        end else begin
                            r_idx   <= r_idx + AW'(1);
                            r_retry <= '0;
                            r_cmd   <= w_rd_data;
                            r_snd   <= 1'b1;
                            r_state <= S_SEND;
                        end
                    end
                    default: r_state <= S_IDLE;
                endcase
            end
        end
    end

    assign cmd      = r_cmd;
    assign snd_cmd  = r_snd;
    assign busy     = r_busy;
    assign done     = r_done;
    assign error    = r_error;
    assign err_code = r_err_code;
    assign cur_idx  = r_idx;

endmodule

// File: tb/tb_cmd_sequencer.sv
// Scoreboard bench: expected command words are queued at stimulus time and
// popped by a monitor on every snd_cmd; a RemoteComm model answers per plan.
import cmd_seq_pkg::*;

module tb_cmd_sequencer;

    localparam int AW = 4;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        wr_en;
    logic [AW-1:0] wr_addr;
    logic [15:0] wr_data;
    logic [AW:0] num_cmds;
    logic [23:0] tmo_val;
    logic        start, abort;
    logic [15:0] cmd;
    logic        snd_cmd, cmd_snt, resp_rdy;
    logic [7:0]  resp;
    logic        busy, done, error;
    logic [1:0]  err_code;
    logic [AW-1:0] cur_idx;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;
    int nsend  = 0;
    logic [15:0] exp_q[$];
    int plan[$];   // per send: 0..255 reply byte, -1 silent, 256+b reply b with abort
    int snt_t[$];
    int snd_t[$];

    cmd_sequencer #(.DEPTH(16), .TMO_W(24), .MAX_RETRY(2), .ACK(8'hA5)) dut (
        .clk(clk), .rst_n(rst_n), .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
        .num_cmds(num_cmds), .tmo_val(tmo_val), .start(start), .abort(abort),
        .cmd(cmd), .snd_cmd(snd_cmd), .cmd_snt(cmd_snt), .resp_rdy(resp_rdy),
        .resp(resp), .busy(busy), .done(done), .error(error), .err_code(err_code),
        .cur_idx(cur_idx)
    );

    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] ex);
        checks++;
        if (act !== ex) begin
            errors++;
            $display("FAIL %s act=%0h exp=%0h", nm, act, ex);
        end
    endtask

    // Monitor: every send must match the next queued word and last one cycle.
    initial begin
        logic prev_snd;
        prev_snd = 1'b0;
        forever begin
            @(negedge clk);
            if (snd_cmd) begin
                nsend++;
                snd_t.push_back(cyc);
                checks++;
                if (prev_snd) begin
                    errors++;
                    $display("FAIL snd_width snd_cmd high two cycles at cyc %0d", cyc);
                end else if (exp_q.size() == 0) begin
                    errors++;
                    $display("FAIL snd_unexpected act=%0h exp=none", cmd);
                end else begin
                    logic [15:0] e;
                    e = exp_q.pop_front();
                    if (cmd !== e) begin
                        errors++;
                        $display("FAIL snd_word act=%0h exp=%0h", cmd, e);
                    end
                end
            end
            prev_snd = snd_cmd;
        end
    end

    // RemoteComm model: cmd_snt 2 cycles after a send, reply 3 cycles later.
    initial begin
        int p;
        cmd_snt = 0; resp_rdy = 0; resp = 0; abort = 0;
        forever begin
            @(negedge clk);
            while (snd_cmd) begin
                p = (plan.size() > 0) ? plan.pop_front() : -1;
                repeat (2) @(negedge clk);
                cmd_snt = 1'b1;
                snt_t.push_back(cyc);
                @(negedge clk);
                cmd_snt = 1'b0;
                if (p >= 0) begin
                    repeat (2) @(negedge clk);
                    resp_rdy = 1'b1;
                    resp     = p[7:0];
                    abort    = (p > 255);
                    @(negedge clk);
                    resp_rdy = 1'b0;
                    abort    = 1'b0;
                end
            end
        end
    end

    task automatic wr(input int a, input logic [15:0] d);
        @(negedge clk);
        wr_en = 1'b1; wr_addr = AW'(a); wr_data = d;
        @(negedge clk);
        wr_en = 1'b0;
    endtask

    task automatic go(input int n, input int t);
        @(negedge clk);
        num_cmds = (AW+1)'(n); tmo_val = 24'(t); start = 1'b1;
        @(negedge clk);
        start = 1'b0;
    endtask

    task automatic wait_end(input int max, output int t);
        logic got;
        got = 1'b0; t = 0;
        for (int i = 0; i < max && !got; i++) begin
            @(negedge clk);
            if (done || error) begin got = 1'b1; t = cyc; end
        end
        chk("end_reached", 32'(got), 32'd1);
    endtask

    task automatic new_test();
        repeat (4) @(negedge clk);
        plan.delete(); snt_t.delete(); snd_t.delete();
    endtask

    initial begin
        int base, t_end;
        #200000;
        $display("FAIL watchdog timeout");
        $fatal(1);
    end

    initial begin
        int base, t_end;
        rst_n = 0; wr_en = 0; wr_addr = '0; wr_data = '0;
        num_cmds = '0; tmo_val = '0; start = 0;
        repeat (3) @(negedge clk);
        chk("rst_cmd", 32'(cmd), 32'h0);
        chk("rst_snd", 32'(snd_cmd), 32'h0);
        chk("rst_busy", 32'(busy), 32'h0);
        chk("rst_done", 32'(done), 32'h0);
        chk("rst_error", 32'(error), 32'h0);
        chk("rst_err_code", 32'(err_code), 32'h0);
        chk("rst_cur_idx", 32'(cur_idx), 32'h0);
        rst_n = 1;

        // Two commands, both ACKed
        new_test();
        wr(0, CAL_GYRO); wr(1, 16'h4BF1);
        plan.push_back(32'hA5); plan.push_back(32'hA5);
        exp_q.push_back(CAL_GYRO); exp_q.push_back(16'h4BF1);
        base = nsend;
        go(2, 100);
        chk("t1_busy", 32'(busy), 32'd1);
        wait_end(500, t_end);
        chk("t1_done", 32'(done), 32'd1);
        chk("t1_error", 32'(error), 32'd0);
        chk("t1_cur_idx", 32'(cur_idx), 32'd1);
        chk("t1_busy_end", 32'(busy), 32'd0);
        chk("t1_sends", 32'(nsend - base), 32'd2);
        chk("t1_q_empty", 32'(exp_q.size()), 32'd0);

        // One NAK then ACK: same word sent twice
        new_test();
        wr(0, 16'h4BF1);
        plan.push_back(32'h5A); plan.push_back(32'hA5);
        exp_q.push_back(16'h4BF1); exp_q.push_back(16'h4BF1);
        base = nsend;
        go(1, 100);
        wait_end(500, t_end);
        chk("t2_done", 32'(done), 32'd1);
        chk("t2_error", 32'(error), 32'd0);
        chk("t2_sends", 32'(nsend - base), 32'd2);

        // Silent responder: three sends, each timing out, then ERR_TMO.
        // cmd_snt is sampled one edge after the cycle it is driven, and the
        // retry/error is seen tmo_val edges after that.
        new_test();
        repeat (3) exp_q.push_back(16'h4BF1);
        base = nsend;
        go(1, 100);
        wait_end(1000, t_end);
        chk("t3_error", 32'(error), 32'd1);
        chk("t3_err_code", 32'(err_code), 32'(ERR_TMO));
        chk("t3_done", 32'(done), 32'd0);
        chk("t3_sends", 32'(nsend - base), 32'd3);
        chk("t3_snt_count", 32'(snt_t.size()), 32'd3);
        if (snt_t.size() == 3 && snd_t.size() == 3) begin
            chk("t3_tmo1", 32'(snd_t[1] - snt_t[0]), 32'd101);
            chk("t3_tmo2", 32'(snd_t[2] - snt_t[1]), 32'd101);
            chk("t3_tmo3", 32'(t_end - snt_t[2]), 32'd101);
        end

        // Abort in the same cycle as an ACK
        new_test();
        wr(0, CAL_GYRO);
        plan.push_back(256 + 32'hA5);
        exp_q.push_back(CAL_GYRO);
        base = nsend;
        go(2, 100);
        wait_end(500, t_end);
        repeat (20) @(negedge clk);
        chk("t4_error", 32'(error), 32'd1);
        chk("t4_err_code", 32'(err_code), 32'(ERR_ABORT));
        chk("t4_done", 32'(done), 32'd0);
        chk("t4_sends", 32'(nsend - base), 32'd1);
        chk("t4_cur_idx", 32'(cur_idx), 32'd0);

        // Empty list: done right after the accepting edge, no send
        new_test();
        base = nsend;
        go(0, 100);
        chk("t5_done", 32'(done), 32'd1);
        chk("t5_error_cleared", 32'(error), 32'd0);
        chk("t5_code_cleared", 32'(err_code), 32'd0);
        chk("t5_busy", 32'(busy), 32'd0);
        repeat (10) @(negedge clk);
        chk("t5_no_send", 32'(nsend - base), 32'd0);

        // Start and write while busy are both dropped
        new_test();
        plan.push_back(32'hA5);
        exp_q.push_back(CAL_GYRO);
        base = nsend;
        go(1, 100);
        @(negedge clk);
        num_cmds = 5'd2; start = 1'b1;
        @(negedge clk);
        start = 1'b0;
        wr(0, 16'hDEAD);
        wait_end(500, t_end);
        repeat (20) @(negedge clk);
        chk("t6_done", 32'(done), 32'd1);
        chk("t6_cur_idx", 32'(cur_idx), 32'd0);
        chk("t6_sends", 32'(nsend - base), 32'd1);

        // Reset while waiting for a response, then replay from slot 0
        new_test();
        exp_q.push_back(CAL_GYRO);
        go(1, 1000);
        repeat (6) @(negedge clk);
        chk("t7_cmd_held", 32'(cmd), 32'(CAL_GYRO));
        chk("t7_busy_pre", 32'(busy), 32'd1);
        rst_n = 1'b0;
        #1;
        chk("t7_rst_cmd", 32'(cmd), 32'h0);
        chk("t7_rst_snd", 32'(snd_cmd), 32'h0);
        chk("t7_rst_busy", 32'(busy), 32'h0);
        chk("t7_rst_done", 32'(done), 32'h0);
        chk("t7_rst_error", 32'(error), 32'h0);
        chk("t7_rst_err_code", 32'(err_code), 32'h0);
        chk("t7_rst_cur_idx", 32'(cur_idx), 32'h0);
        @(negedge clk);
        rst_n = 1'b1;
        new_test();
        plan.push_back(32'hA5); plan.push_back(32'hA5);
        exp_q.push_back(CAL_GYRO); exp_q.push_back(16'h4BF1);
        base = nsend;
        go(2, 100);
        wait_end(500, t_end);
        chk("t7_done", 32'(done), 32'd1);
        chk("t7_cur_idx", 32'(cur_idx), 32'd1);
        chk("t7_sends", 32'(nsend - base), 32'd2);
        chk("t7_q_empty", 32'(exp_q.size()), 32'd0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule

// File: doc/cmd_sequencer.md
# cmd_sequencer

Parametrised command sequencer that plays a stored list of 16-bit Knight commands into RemoteComm, one at a time. Each command is sent, then the block waits for its positive acknowledge before sending the next. It is the synthesizable, generalised successor of the bench-level send/ack/timeout procedure. It sits between a host loader, or a fixed tour image, and RemoteComm's `cmd`/`snd_cmd`/`cmd_snt`/`resp_rdy`/`resp` handshake. Over the single-command flow it adds:
- per-command timeout,
- bounded retry on NAK or timeout,
- abort,
- error reporting.

## Interface
Parameters:
- DEPTH, 16: command slots; power of two, 2..256.
- TMO_W, 24: width of the response timeout counter.
- MAX_RETRY, 2: resends allowed per command after the first send.
- ACK, 8'hA5: response byte counted as a positive acknowledge.

Ports (AW = $clog2(DEPTH)):
- clk  in  1  system clock.
- rst_n  in  1  asynchronous active-low reset.
- wr_en  in  1  write `wr_data` into slot `wr_addr`; ignored while `busy`.
- wr_addr  in  AW  slot index.
- wr_data  in  16  command word.
- num_cmds  in  AW+1  number of slots to play, 0..DEPTH; sampled on `start`.
- tmo_val  in  TMO_W  clocks allowed for `resp_rdy` after `cmd_snt`; sampled on `start`.
- start  in  1  begin playback from slot 0; ignored while `busy`.
- abort  in  1  stop playback.
- cmd  out  16  command to RemoteComm.
- snd_cmd  out  1  one-cycle send pulse to RemoteComm.
- cmd_snt  in  1  RemoteComm finished transmitting.
- resp_rdy  in  1  response byte valid (one-cycle pulse).
- resp  in  8  response byte.
- busy  out  1  high from `start` acceptance until DONE/ERR.
- done  out  1  sticky; list completed.
- error  out  1  sticky; playback failed.
- err_code  out  2  0 none, 1 timeout, 2 NAK, 3 aborted.
- cur_idx  out  AW  slot currently in flight, or last slot attempted.

## Operation
- States: IDLE, SEND, WAIT_SNT, WAIT_RESP, NEXT, DONE, ERR.
- IDLE:
  - `start` with `num_cmds`=0 → DONE.
  - Otherwise latch `num_cmds` and `tmo_val`, set idx=0 and retry=0, clear `done`/`error`/`err_code`, go to SEND.
- SEND:
  - Register `cmd` = mem[idx].
  - Assert `snd_cmd` for exactly this one cycle, then go to WAIT_SNT.
- WAIT_SNT: on `cmd_snt`, clear the timeout counter and go to WAIT_RESP. This state has no timeout.
- WAIT_RESP, checked in this order each cycle:
  1. `resp_rdy` && `resp`==ACK → NEXT.
  2. `resp_rdy` && `resp`!=ACK → retry path with code 2.
  3. Counter == tmo_val-1 → retry path with code 1.
  4. Otherwise increment the counter.
- Retry path:
  - If retry < MAX_RETRY: retry++, go to SEND.
  - Else: latch `err_code`, go to ERR.
- NEXT:
  - If idx == num_cmds-1 → DONE.
  - Else idx++, retry=0, go to SEND.
- DONE: `done`=1. ERR: `error`=1. Both go to IDLE next cycle; the flags stay set until the next accepted `start`.
- `abort`:
  - In any state other than IDLE/DONE/ERR it forces ERR with code 3 on the next edge.
  - It takes priority over a simultaneous `resp_rdy` or `cmd_snt`.
- `resp_rdy` outside WAIT_RESP is ignored; it is neither counted nor stored.
- `start` while `busy` is ignored. `wr_en` while `busy` is dropped and memory is unchanged.
- An `idx` overflow cannot occur, because `num_cmds` ≤ DEPTH.
- `cmd` holds its value from SEND until the next SEND.

## Timing
- Reset values:
  - Outputs: `cmd`=0, `snd_cmd`=0, `busy`=0, `done`=0, `error`=0, `err_code`=0, `cur_idx`=0, state IDLE.
  - Memory is not reset.
- `start` accepted at edge N → `snd_cmd` high during cycle N+1 → `busy` high from N+1.
- Accepting ACK at edge M → NEXT at M+1 → next `snd_cmd` at M+2. The last command reaches DONE at M+2 instead.
- Timeout fires exactly `tmo_val` clocks after the `cmd_snt` cycle. `tmo_val`=0 is treated as 1.
- Reset mid-playback returns to IDLE immediately with all outputs at their reset values. No `snd_cmd` is issued.
- Written memory is readable by a SEND starting one cycle after the write.

## Structure
- `cmd_seq_pkg` holds:
  - the state enum,
  - the err_code enum (ERR_NONE, ERR_TMO, ERR_NAK, ERR_ABORT),
  - ACK/NAK byte constants,
  - shared command constants (e.g. CAL_GYRO), for reuse by benches and the tour generator.
- One sub-module: `cmd_mem`, a DEPTH×16 synchronous-write, asynchronous-read register file.

## Test plan
- Load [CAL_GYRO, 16'h4BF1], num_cmds=2, responder ACKs each → two `snd_cmd` pulses in order, `done`=1, `error`=0, `cur_idx`=1.
- Responder returns 8'h5A once, then ACK (MAX_RETRY=2) → 16'h4BF1 is sent twice, then `done`=1.
- Responder stays silent, tmo_val=100 → 3 sends, each timing out exactly 100 clocks after `cmd_snt`, then `error`=1, `err_code`=1.
- `abort` in the same cycle as an ACK `resp_rdy` → `err_code`=3, `done`=0, no further `snd_cmd`.
- num_cmds=0 `start` → `done` one cycle later and no `snd_cmd`. A second `start` while `busy` is ignored, shown by `cur_idx` and the send count.
- Deassert rst_n while in WAIT_RESP → all outputs at reset values immediately. After release, a fresh `start` replays from slot 0.
